// File: rtl/proto_monitor.sv
// proto_monitor: runtime protocol monitor for NCH independent channels.
// Each channel is checked for three rule sets: req->ack latency window,
// maximum err burst length, and the rdy/interrupt hand-off. Violations land
// in sticky per-channel code bits, a saturating event counter and an irq line.
module proto_monitor #(
  parameter int NCH         = 2,
  parameter int ACK_MIN     = 5,
  parameter int ACK_MAX     = 5,
  parameter int LAT_W       = 8,
  parameter int ERR_MAX_LEN = 3,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [NCH-1:0]       ack,
  input  logic [NCH-1:0]       err,
  input  logic [NCH-1:0]       rdy,
  input  logic [NCH-1:0]       interrupt,
  input  logic                 clr,
  output logic [5*NCH-1:0]     viol_code,
  output logic [CNT_W-1:0]     viol_cnt,
  output logic                 irq
);

  // Run counter only needs to reach ERR_MAX_LEN+1 (the saturation point).
  localparam int RUN_W = $clog2(ERR_MAX_LEN + 2);

  localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
  localparam logic [LAT_W-1:0] ACK_MIN_L = LAT_W'(ACK_MIN);
  localparam logic [LAT_W-1:0] ACK_MAX_L = LAT_W'(ACK_MAX);

  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(ERR_MAX_LEN);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(ERR_MAX_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } req_state_e;

  // Violations raised on the current edge, five bits per channel:
  // {rdy hand-off, err burst, protocol, early ack, timeout}.
  logic [5*NCH-1:0] new_viol;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch

    req_state_e       state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             flag_timeout;
    logic             flag_early;
    logic             flag_spurious;
    logic             flag_overlap;

    logic [RUN_W-1:0] run_q, run_d;
    logic             flag_burst;

    logic             rdy_q, rdy_d;
    logic             int_q, int_d;
    logic             flag_handoff;

    // Request/ack tracker: lat counts edges since the accepted req.
    always_comb begin
      state_d       = state_q;
      lat_d         = lat_q;
      flag_timeout  = 1'b0;
      flag_early    = 1'b0;
      flag_spurious = 1'b0;
      flag_overlap  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // An ack with nothing outstanding is spurious; a coincident req
          // is still accepted.
          if (ack[gi]) begin
            flag_spurious = 1'b1;
          end
          if (req[gi]) begin
            state_d = ST_WAIT;
            lat_d   = LAT_ONE;
          end
        end
        ST_WAIT: begin
          if (ack[gi]) begin
            flag_early = (lat_q < ACK_MIN_L);
            // A req on the ack edge starts the next transaction directly.
            if (req[gi]) begin
              lat_d = LAT_ONE;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            // Overlapping req is dropped; the running timer is untouched.
            flag_overlap = req[gi];
            if (lat_q == ACK_MAX_L) begin
              flag_timeout = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              lat_d = lat_q + LAT_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Err burst: saturating run length, flagged once as the run crosses the limit.
    always_comb begin
      flag_burst = err[gi] && (run_q == RUN_LIM);
      if (!err[gi]) begin
        run_d = '0;
      end else if (run_q == RUN_SAT) begin
        run_d = run_q;
      end else begin
        run_d = run_q + RUN_ONE;
      end
    end

    // Rdy hand-off: rdy may only drop after an interrupt, and must drop after one.
    always_comb begin
      rdy_d        = rdy[gi];
      int_d        = interrupt[gi];
      flag_handoff = rdy_q & ((~int_q & ~rdy[gi]) | (int_q & rdy[gi]));
    end

    assign new_viol[5*gi +: 5] = {flag_handoff,
                                  flag_burst,
                                  flag_spurious | flag_overlap,
                                  flag_early,
                                  flag_timeout};

    // Per-channel state; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= ST_IDLE;
        lat_q   <= '0;
        run_q   <= '0;
        rdy_q   <= 1'b0;
        int_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        lat_q   <= lat_d;
        run_q   <= run_d;
        rdy_q   <= rdy_d;
        int_q   <= int_d;
      end
    end

  end : g_ch

  logic [5*NCH-1:0] viol_code_q, viol_code_d;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic [CNT_W-1:0] cnt_base;
  logic             irq_q, irq_d;

  // Sticky code, event counter and irq; a violation on a clr edge survives the clear.
  always_comb begin
    viol_code_d = (clr ? '0 : viol_code_q) | new_viol;
    cnt_base    = clr ? '0 : viol_cnt_q;
    viol_cnt_d  = cnt_base;
    if ((|new_viol) && (cnt_base != '1)) begin
      viol_cnt_d = cnt_base + CNT_ONE;
    end
    irq_d = |viol_code_d;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      viol_code_q <= '0;
      viol_cnt_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      viol_code_q <= viol_code_d;
      viol_cnt_q  <= viol_cnt_d;
      irq_q       <= irq_d;
    end
  end

  assign viol_code = viol_code_q;
  assign viol_cnt  = viol_cnt_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_proto_monitor.sv
// Testbench for proto_monitor: directed scenarios followed by random traffic,
// every edge compared against a timestamp-based reference model.
module tb_proto_monitor;

  localparam int NCH         = 2;
  localparam int ACK_MIN     = 5;
  localparam int ACK_MAX     = 5;
  localparam int LAT_W       = 8;
  localparam int ERR_MAX_LEN = 3;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic                 clk;
  logic                 rst;
  logic [NCH-1:0]       req;
  logic [NCH-1:0]       ack;
  logic [NCH-1:0]       err;
  logic [NCH-1:0]       rdy;
  logic [NCH-1:0]       interrupt;
  logic                 clr;
  logic [5*NCH-1:0]     viol_code;
  logic [CNT_W-1:0]     viol_cnt;
  logic                 irq;

  proto_monitor #(
    .NCH(NCH), .ACK_MIN(ACK_MIN), .ACK_MAX(ACK_MAX), .LAT_W(LAT_W),
    .ERR_MAX_LEN(ERR_MAX_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .err(err), .rdy(rdy),
    .interrupt(interrupt), .clr(clr),
    .viol_code(viol_code), .viol_cnt(viol_cnt), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int step_n = 0;

  // Reference model: outstanding request tracked by the edge number it was issued on.
  int               edge_n;
  bit               m_pend  [NCH];
  int               m_issue [NCH];
  int               m_run   [NCH];
  bit               m_prdy  [NCH];
  bit               m_pint  [NCH];
  logic [5*NCH-1:0] m_code;
  int               m_cnt;
  logic             m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    edge_n = 0;
    for (int c = 0; c < NCH; c++) begin
      m_pend[c]  = 1'b0;
      m_issue[c] = 0;
      m_run[c]   = 0;
      m_prdy[c]  = 1'b0;
      m_pint[c]  = 1'b0;
    end
    m_code = '0;
    m_cnt  = 0;
    m_irq  = 1'b0;
  endtask

  task automatic model_edge(input logic [NCH-1:0] rq, input logic [NCH-1:0] ak,
                            input logic [NCH-1:0] er, input logic [NCH-1:0] rd,
                            input logic [NCH-1:0] it, input logic cl);
    logic [5*NCH-1:0] nv;
    logic [4:0]       v;
    int               d;
    int               base;
    edge_n++;
    nv = '0;
    for (int c = 0; c < NCH; c++) begin
      v = '0;
      if (!m_pend[c]) begin
        if (ak[c]) v[2] = 1'b1;
        if (rq[c]) begin
          m_pend[c]  = 1'b1;
          m_issue[c] = edge_n;
        end
      end else begin
        d = edge_n - m_issue[c];
        if (ak[c]) begin
          if (d < ACK_MIN) v[1] = 1'b1;
          if (rq[c]) m_issue[c] = edge_n;
          else       m_pend[c]  = 1'b0;
        end else begin
          if (rq[c]) v[2] = 1'b1;
          if (d >= ACK_MAX) begin
            v[0]      = 1'b1;
            m_pend[c] = 1'b0;
          end
        end
      end
      if (er[c]) m_run[c]++;
      else       m_run[c] = 0;
      if (m_run[c] == ERR_MAX_LEN + 1) v[3] = 1'b1;
      if (m_prdy[c] && ((!m_pint[c] && !rd[c]) || (m_pint[c] && rd[c]))) v[4] = 1'b1;
      m_prdy[c] = rd[c];
      m_pint[c] = it[c];
      nv[5*c +: 5] = v;
    end
    m_code = (cl ? '0 : m_code) | nv;
    base   = cl ? 0 : m_cnt;
    if (nv != '0) m_cnt = (base + 1 > CNT_MAX) ? CNT_MAX : base + 1;
    else          m_cnt = base;
    m_irq = (m_code != '0);
  endtask

  // One clock edge with the given inputs, checked against the model.
  task automatic step(input logic [NCH-1:0] rq, input logic [NCH-1:0] ak,
                      input logic [NCH-1:0] er, input logic [NCH-1:0] rd,
                      input logic [NCH-1:0] it, input logic cl);
    req = rq; ack = ak; err = er; rdy = rd; interrupt = it; clr = cl;
    @(posedge clk);
    model_edge(rq, ak, er, rd, it, cl);
    #1;
    step_n++;
    $display("step %0d req=%b ack=%b err=%b rdy=%b int=%b clr=%b code=%b cnt=%0d irq=%b",
             step_n, rq, ak, er, rd, it, cl, viol_code, viol_cnt, irq);
    chk("code", 32'(viol_code), 32'(m_code));
    chk("cnt",  32'(viol_cnt),  32'(m_cnt));
    chk("irq",  32'(irq),       32'(m_irq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_code", 32'(viol_code), 32'(0));
    chk("rst_cnt",  32'(viol_cnt),  32'(0));
    chk("rst_irq",  32'(irq),       32'(0));
    #2 rst = 1'b1;
  endtask

  int sched [NCH];

  initial begin
    logic [NCH-1:0] rq, ak, er, rd, it;
    logic           cl;

    rst = 1'b0; req = '0; ack = '0; err = '0; rdy = '0; interrupt = '0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_code", 32'(viol_code), 32'(0));
    chk("reset_cnt",  32'(viol_cnt),  32'(0));
    chk("reset_irq",  32'(irq),       32'(0));
    #2 rst = 1'b1;

    // 1: legal transaction, ack exactly ACK_MIN edges after req
    idle(2);
    step(2'b01, '0, '0, '0, '0, 1'b0);
    idle(4);
    step('0, 2'b01, '0, '0, '0, 1'b0);
    chk("t1_code", 32'(viol_code), 32'(0));
    chk("t1_cnt",  32'(viol_cnt),  32'(0));

    // 2: early ack (d=3), then a timeout
    step(2'b01, '0, '0, '0, '0, 1'b0);
    idle(2);
    step('0, 2'b01, '0, '0, '0, 1'b0);
    chk("t2_early", 32'(viol_code[1]), 32'(1));
    chk("t2_cnt1",  32'(viol_cnt),     32'(1));
    step(2'b01, '0, '0, '0, '0, 1'b0);
    idle(4);
    chk("t2_no_timeout_yet", 32'(viol_code[0]), 32'(0));
    idle(1);
    chk("t2_timeout", 32'(viol_code[0]), 32'(1));
    chk("t2_cnt2",    32'(viol_cnt),     32'(2));

    // 3: ch1 err burst of 4 flags once; a burst of 3 is legal
    step('0, '0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step('0, '0, 2'b10, '0, '0, 1'b0);
    chk("t3_burst_early", 32'(viol_code[8]), 32'(0));
    step('0, '0, 2'b10, '0, '0, 1'b0);
    chk("t3_burst", 32'(viol_code[8]), 32'(1));
    chk("t3_cnt",   32'(viol_cnt),     32'(1));
    for (int i = 0; i < 3; i++) step('0, '0, 2'b10, '0, '0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) step('0, '0, 2'b10, '0, '0, 1'b0);
    idle(1);
    chk("t3_cnt_hold", 32'(viol_cnt), 32'(1));

    // 4: ch0 rdy held after interrupt, ch1 rdy dropped without one, same edge
    step('0, '0, '0, 2'b11, 2'b01, 1'b0);
    step('0, '0, '0, 2'b01, 2'b00, 1'b0);
    chk("t4_ch0_rdy", 32'(viol_code[4]), 32'(1));
    chk("t4_ch1_rdy", 32'(viol_code[9]), 32'(1));
    chk("t4_cnt",     32'(viol_cnt),     32'(2));
    pulse_reset();

    // 5: transaction abandoned by reset, then clr on a violation edge
    step(2'b01, '0, '0, '0, '0, 1'b0);
    idle(1);
    pulse_reset();
    idle(6);
    chk("t5_no_timeout", 32'(viol_code), 32'(0));
    step('0, 2'b01, '0, '0, '0, 1'b0);
    chk("t5_spurious", 32'(viol_code[2]), 32'(1));
    step('0, 2'b10, '0, '0, '0, 1'b1);
    chk("t5_clr_code", 32'(viol_code), 32'(10'b00100_00000));
    chk("t5_clr_cnt",  32'(viol_cnt),  32'(1));
    chk("t5_clr_irq",  32'(irq),       32'(1));

    // 6: counter saturation, irq held until clr
    step('0, '0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 20; i++) step('0, 2'b01, '0, '0, '0, 1'b0);
    chk("t6_sat", 32'(viol_cnt), 32'(15));
    idle(3);
    chk("t6_sat_hold", 32'(viol_cnt), 32'(15));
    chk("t6_irq_hold", 32'(irq),      32'(1));
    step('0, '0, '0, '0, '0, 1'b1);
    chk("t6_clr_cnt", 32'(viol_cnt), 32'(0));
    chk("t6_clr_irq", 32'(irq),      32'(0));

    // Random traffic, with some acks scheduled to land near the legal window
    pulse_reset();
    for (int c = 0; c < NCH; c++) sched[c] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NCH; c++) begin
        rq[c] = ($urandom_range(0, 9) == 0);
        ak[c] = ($urandom_range(0, 19) == 0);
        if (sched[c] > 0) begin
          sched[c]--;
          if (sched[c] == 0) ak[c] = 1'b1;
        end
        if (rq[c] && sched[c] == 0) sched[c] = $urandom_range(3, 7);
        er[c] = ($urandom_range(0, 2) != 0);
        rd[c] = ($urandom_range(0, 3) != 0);
        it[c] = ($urandom_range(0, 3) == 0);
      end
      cl = ($urandom_range(0, 29) == 0);
      step(rq, ak, er, rd, it, cl);
      if ($urandom_range(0, 149) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
